// File: rtl/rlwe_decrypt_if.sv
// Handshake and data bundle for the serial ring-LWE decryptor.
// The master side supplies ciphertext, secret and out_ready.
// The slave side (the decryptor) returns in_ready, m_out and out_valid.
interface rlwe_decrypt_if #(
  parameter int N = 4,
  parameter int Q = 10
);
  logic         in_valid;
  logic         in_ready;
  logic [Q-1:0] c1_0_in;
  logic [Q-1:0] c1_1_in;
  logic [Q-1:0] c1_2_in;
  logic [Q-1:0] c1_3_in;
  logic [Q-1:0] c2_0_in;
  logic [Q-1:0] c2_1_in;
  logic [Q-1:0] c2_2_in;
  logic [Q-1:0] c2_3_in;
  logic [N-1:0] s_in;
  logic [N-1:0] m_out;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in_valid, c1_0_in, c1_1_in, c1_2_in, c1_3_in,
           c2_0_in, c2_1_in, c2_2_in, c2_3_in, s_in, out_ready,
    input  in_ready, m_out, out_valid
  );

  modport slave (
    input  in_valid, c1_0_in, c1_1_in, c1_2_in, c1_3_in,
           c2_0_in, c2_1_in, c2_2_in, c2_3_in, s_in, out_ready,
    output in_ready, m_out, out_valid
  );
endinterface

// File: rtl/rlwe_decrypt.sv
// Serial ring-LWE decryptor over Z_(2^Q)[x]/(x^N+1).
// Computes d = c2 - c1*s one negacyclic coefficient per clock and decodes
// each coefficient to a message bit (1 iff d_k lies in [2^(Q-2), 3*2^(Q-2))).
// The rotate register holds c1'_(k-j) at position j during cycle k, so the
// product coefficient is just the s-masked sum of the register contents.
module rlwe_decrypt (
  input logic           clk,
  input logic           rst,
  rlwe_decrypt_if.slave bus
);
  localparam int N  = 4;
  localparam int Q  = 10;
  localparam int KW = $clog2(N);

  typedef enum logic [1:0] {IDLE, COMPUTE, HOLD} state_t;

  state_t        state_reg;
  logic [Q-1:0]  rot_reg [N];
  logic [Q-1:0]  c2_reg  [N];
  logic [N-1:0]  s_reg;
  logic [N-1:0]  m_reg;
  logic [KW-1:0] k_reg;
  logic          in_ready_reg;
  logic          out_valid_reg;

  logic [Q-1:0]  c1_in       [N];
  logic [Q-1:0]  c2_in       [N];
  logic [Q-1:0]  rot_init    [N];
  logic [Q-1:0]  rot_next    [N];
  logic [Q-1:0]  term        [N];
  logic [Q-1:0]  v_sum;
  logic [Q-1:0]  d_coef;
  logic          m_bit;

  // Gather the flat coefficient ports into arrays.
  always_comb begin
    c1_in[0] = bus.c1_0_in;
    c1_in[1] = bus.c1_1_in;
    c1_in[2] = bus.c1_2_in;
    c1_in[3] = bus.c1_3_in;
    c2_in[0] = bus.c2_0_in;
    c2_in[1] = bus.c2_1_in;
    c2_in[2] = bus.c2_2_in;
    c2_in[3] = bus.c2_3_in;
  end

  // Capture order: position j gets c1'_(-j), i.e. c1_0 then -c1_(N-j).
  // Rotation step: shift up one slot, negating what wraps into slot 0.
  // Masking: each slot contributes only when its secret bit is set.
  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    if (gi == 0) begin : g_head
      assign rot_init[gi] = c1_in[0];
      assign rot_next[gi] = Q'(0) - rot_reg[N-1];
    end else begin : g_tail
      assign rot_init[gi] = Q'(0) - c1_in[N-gi];
      assign rot_next[gi] = rot_reg[gi-1];
    end
    assign term[gi] = s_reg[gi] ? rot_reg[gi] : '0;
  end

  // Sum of masked terms gives v_k; subtract from c2_k and decode one bit.
  always_comb begin
    v_sum = '0;
    for (int j = 0; j < N; j++) begin
      v_sum = v_sum + term[j];
    end
    d_coef = c2_reg[k_reg] - v_sum;
    m_bit  = d_coef[Q-1] ^ d_coef[Q-2];
  end

  // Control FSM plus datapath registers; all outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      k_reg         <= '0;
      s_reg         <= '0;
      m_reg         <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      for (int j = 0; j < N; j++) begin
        rot_reg[j] <= '0;
        c2_reg[j]  <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            for (int j = 0; j < N; j++) begin
              rot_reg[j] <= rot_init[j];
              c2_reg[j]  <= c2_in[j];
            end
            s_reg        <= bus.s_in;
            m_reg        <= '0;
            k_reg        <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= COMPUTE;
          end
        end
        COMPUTE: begin
          m_reg[k_reg] <= m_bit;
          for (int j = 0; j < N; j++) begin
            rot_reg[j] <= rot_next[j];
          end
          if (k_reg == KW'(N - 1)) begin
            k_reg         <= '0;
            out_valid_reg <= 1'b1;
            state_reg     <= HOLD;
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.m_out     = m_reg;
endmodule
